ov7670_sccb_config: RTL and testbench
=====================================

// Module: ov7670_sccb_config
// PURPOSE
// - Boot-time configuration sequencer for the OV7670 camera in the capture-to-VRAM-to-VGA path.
// - Walks a register table and writes each entry to the sensor over SCCB, a write-only 3-phase I2C variant.
// - Entry format: {reg_addr[15:8], reg_data[7:0]}.
// - Raises done_o when the whole table is written, so capture logic can trust the pixel format.
// PARAMETERS
// - CLK_FREQ_HZ      100_000_000  system clock frequency.
// - SCCB_FREQ_HZ     100_000      SIOC frequency. CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) is an integer >= 1.
// - SLAVE_ADDR       8'h42        OV7670 write address (phase 1 byte).
// - NUM_ENTRIES      64           table depth. Index width is $clog2(NUM_ENTRIES).
// - DELAY_CYCLES     1_000_000    wait length for the DELAY token (10 ms at 100 MHz).
// PORTS
// - clk_i       in   1   system clock.
// - reset_i     in   1   asynchronous, active-high reset.
// - start_i     in   1   1-cycle pulse; starts a full table write.
// - sioc_o      out  1   SCCB clock, push-pull.
// - siod_o      out  1   SCCB data value. Meaningful only when siod_oe_o=1.
// - siod_oe_o   out  1   1 = drive siod_o; 0 = release (pulled high at top level).
// - busy_o      out  1   high from start acceptance until done.
// - done_o      out  1   high after the table completes; cleared by the next accepted start.
// - index_o     out  $clog2(NUM_ENTRIES)  current table index (debug/LED).
// BEHAVIOUR
// - Reset values: sioc_o=1, siod_o=1, siod_oe_o=0, busy_o=0, done_o=0, index_o=0, FSM=IDLE.
// - Reset applies immediately, including mid-transaction. The bus is released; no STOP is generated.
// - Quarter tick: a counter pulses tick every Q=CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) clk cycles. It runs only while busy_o=1.
// - Every bus action advances only on tick.
// - FSM states: IDLE, LOAD, START, BIT, STOP, GAP, DELAY, DONE.
// - IDLE/DONE: start_i=1 -> busy_o=1, done_o=0, index=0, go to LOAD. start_i is ignored in all other states.
// - LOAD (1 clk): read the ROM.
//   - Entry 16'hFFFF, or index==NUM_ENTRIES -> DONE: busy_o=0, done_o=1.
//   - Entry 16'hFFF0 -> DELAY.
//   - Otherwise latch the 27-bit shift word {SLAVE_ADDR,X, addr,X, data,X}, bits sent MSB first, X = don't-care. Go to START.
// - START (2 quarters), starting with SIOC=1 and SIOD released:
//   - q0: drive SIOD=0 while SIOC=1.
//   - q1: SIOC=0.
// - BIT (27 bits x 4 quarters):
//   - q0: SIOC=0, present the bit.
//   - q1: hold.
//   - q2: SIOC=1.
//   - q3: hold, then shift.
//   - X bits (bit positions 8, 17, 26 of the sequence): siod_oe_o=0, slave ACK is ignored.
// - STOP (3 quarters):
//   - q0: SIOC=0, SIOD=0.
//   - q1: SIOC=1.
//   - q2: release SIOD (rising edge with SIOC high).
// - GAP: 4 quarters idle with the bus released. Then index+1 -> LOAD.
// - DELAY: count DELAY_CYCLES clks, bus released. Then index+1 -> LOAD.
// - SIOD changes only while SIOC=0, except at START q0 and STOP q2.
// - Per-write duration: (2+108+3+4)*Q clks, plus 1 clk for LOAD.
// - sioc_o idles high whenever busy_o=0.
// STRUCTURE
// - Package ov7670_pkg holds:
//   - typedef enum sccb_state_t
//   - localparams CFG_END=16'hFFFF, CFG_DELAY=16'hFFF0, SCCB_BITS=27
//   - the RGB565/VGA default register list
// - Sub-module ov7670_cfg_rom: combinational index -> 16-bit entry. Unused entries return CFG_END.
// TESTING
// - Run with CLK_FREQ_HZ=4_000_000, SCCB_FREQ_HZ=1_000_000 (Q=1), DELAY_CYCLES=20, NUM_ENTRIES=4.
// 1. Reset held -> sioc_o=1, siod_oe_o=0, busy_o=0, done_o=0. Deassert with no start -> outputs unchanged for 100 clks.
// 2. ROM {12_80, FFFF}, pulse start -> bus model decodes bytes 42,12,80; SIOC period = 4 clks.
//    - START/STOP edges occur while SIOC=1.
//    - done_o rises 1+117+1 clks after start; busy_o low in the same cycle.
// 3. ROM {12_80, FFF0, 40_D0, FFFF} -> two writes decoded; bus idle >=20 clks between them; index_o ends at 3.
// 4. start_i pulsed again mid-transaction -> ignored: same write count, same done timing.
//    - start after done -> done_o=0 next clk and the table is rewritten.
// 5. reset_i asserted during BIT -> same cycle sioc_o=1, siod_oe_o=0, busy_o=0. A following start rewrites from index 0.
// 6. ROM with no FFFF in 4 entries -> exactly 4 writes, then done_o=1.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer,
// including the default RGB565 / VGA register list.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_GAP,
    ST_DELAY,
    ST_DONE
  } sccb_state_t;

  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;
  localparam int          SCCB_BITS = 27;

  // Soft reset, settle, then RGB565 at VGA resolution with sane colour matrix.
  localparam int DEFAULT_CFG_LEN = 35;
  localparam logic [15:0] DEFAULT_CFG [DEFAULT_CFG_LEN] = '{
    16'h1280, 16'hFFF0, 16'h1204, 16'h1180, 16'h0C00, 16'h3E00, 16'h0400,
    16'h40D0, 16'h3A04, 16'h1418, 16'h4FB3, 16'h50B3, 16'h5100, 16'h523D,
    16'h53A7, 16'h54E4, 16'h589E, 16'h3DC0, 16'h1714, 16'h1802, 16'h3280,
    16'h1903, 16'h1A7B, 16'h030A, 16'h0F41, 16'h1E00, 16'h330B, 16'h3C78,
    16'h6900, 16'h7400, 16'hB084, 16'hB10C, 16'hB20E, 16'hB380, 16'hFFFF
  };

  function automatic logic [15:0] default_cfg_entry(input int idx);
    if (idx < DEFAULT_CFG_LEN) return DEFAULT_CFG[idx];
    return CFG_END;
  endfunction

  // Positions 8, 17 and 26 are the 9th-bit slots where the slave may answer.
  function automatic logic sccb_dont_care(input logic [4:0] bit_idx);
    return (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// Combinational register table: index -> {reg_addr, reg_data}.
// Slots past the table (or past NUM_ENTRIES) read as CFG_END.
module ov7670_cfg_rom
  import ov7670_pkg::*;
#(
  parameter int                        NUM_ENTRIES  = 64,
  parameter bit                        USE_CUSTOM   = 1'b0,
  parameter logic [16*NUM_ENTRIES-1:0] CUSTOM_TABLE = '0,
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic [IDX_W-1:0] index_i,
  output logic [15:0]      entry_o
);

  always_comb begin
    entry_o = CFG_END;
    if (int'(index_i) < NUM_ENTRIES) begin
      if (USE_CUSTOM) entry_o = CUSTOM_TABLE[16*int'(index_i) +: 16];
      else            entry_o = default_cfg_entry(int'(index_i));
    end
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// Boot-time OV7670 register loader: walks the config ROM and writes each
// entry as a 3-phase SCCB write, raising done_o once the table is exhausted.
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int unsigned               CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned               SCCB_FREQ_HZ     = 100_000,
  parameter logic [7:0]                SLAVE_ADDR       = 8'h42,
  parameter int                        NUM_ENTRIES      = 64,
  parameter int unsigned               DELAY_CYCLES     = 1_000_000,
  parameter bit                        USE_CUSTOM_TABLE = 1'b0,
  parameter logic [16*NUM_ENTRIES-1:0] CUSTOM_TABLE     = '0,
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  output logic             sioc_o,
  output logic             siod_o,
  output logic             siod_oe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] index_o
);

  localparam int unsigned Q  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int          QW = (Q > 1) ? $clog2(Q) : 1;
  localparam int          DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [QW-1:0]  Q_LAST  = QW'(Q - 1);
  localparam logic [DW-1:0]  D_LAST  = DW'(DELAY_CYCLES - 1);
  localparam logic [IDX_W:0] IDX_END = (IDX_W + 1)'(NUM_ENTRIES);
  localparam logic [IDX_W:0] IDX_ONE = (IDX_W + 1)'(1);

  sccb_state_t          state_q;
  logic [QW-1:0]        qcnt_q, qcnt_d;
  logic [1:0]           qtr_q;
  logic [4:0]           bit_q;
  logic [SCCB_BITS-1:0] shift_q;
  logic [DW-1:0]        dcnt_q;
  logic [IDX_W:0]       idx_q;
  logic [15:0]          entry;
  logic                 tick;

  ov7670_cfg_rom #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .USE_CUSTOM  (USE_CUSTOM_TABLE),
    .CUSTOM_TABLE(CUSTOM_TABLE)
  ) u_rom (
    .index_i(idx_q[IDX_W-1:0]),
    .entry_o(entry)
  );

  assign index_o = idx_q[IDX_W-1:0];
  assign tick    = busy_o && (qcnt_q == Q_LAST);

  // Quarter-period timer; re-phased in LOAD so each write starts on a full quarter.
  always_comb begin
    qcnt_d = qcnt_q + QW'(1);
    if (!busy_o || state_q == ST_LOAD || tick) qcnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) qcnt_q <= '0;
    else         qcnt_q <= qcnt_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      sioc_o    <= 1'b1;
      siod_o    <= 1'b1;
      siod_oe_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      idx_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      dcnt_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (idx_q == IDX_END || entry == CFG_END) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= ST_DONE;
          end else if (entry == CFG_DELAY) begin
            dcnt_q  <= '0;
            state_q <= ST_DELAY;
          end else begin
            // X slots are sent as 1 but never driven.
            shift_q   <= {SLAVE_ADDR, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
            sioc_o    <= 1'b1;
            siod_o    <= 1'b0;
            siod_oe_o <= 1'b1;
            qtr_q     <= '0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (qtr_q == 2'd0) begin
              sioc_o <= 1'b0;
              qtr_q  <= 2'd1;
            end else begin
              bit_q     <= '0;
              qtr_q     <= '0;
              siod_o    <= shift_q[SCCB_BITS-1];
              siod_oe_o <= 1'b1;
              state_q   <= ST_BIT;
            end
          end
        end
        ST_BIT: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd1) begin
              sioc_o <= 1'b1;
            end else if (qtr_q == 2'd3) begin
              sioc_o <= 1'b0;
              if (bit_q == 5'(SCCB_BITS - 1)) begin
                siod_o    <= 1'b0;
                siod_oe_o <= 1'b1;
                state_q   <= ST_STOP;
              end else begin
                bit_q     <= bit_q + 5'd1;
                shift_q   <= shift_q << 1;
                siod_o    <= shift_q[SCCB_BITS-2];
                siod_oe_o <= !sccb_dont_care(bit_q + 5'd1);
              end
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd0) begin
              sioc_o <= 1'b1;
            end else if (qtr_q == 2'd1) begin
              siod_o    <= 1'b1;
              siod_oe_o <= 1'b0;
            end else begin
              qtr_q   <= '0;
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              idx_q   <= idx_q + IDX_ONE;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_DELAY: begin
          if (dcnt_q == D_LAST) begin
            idx_q   <= idx_q + IDX_ONE;
            state_q <= ST_LOAD;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: three instances with different 4-entry tables,
// an SCCB bus decoder and a queue of expected writes.
module tb_ov7670_sccb_config;

  localparam int N = 4;
  localparam logic [63:0] ROM_A = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1280};
  localparam logic [63:0] ROM_B = {16'hFFFF, 16'h40D0, 16'hFFF0, 16'h1280};
  localparam logic [63:0] ROM_C = {16'h55AA, 16'h40D0, 16'h3456, 16'h1280};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [2:0] sioc, siod, oe, busy, done;
  logic [1:0] idx [3];
  int         sel;

  always #5 clk = ~clk;

  ov7670_sccb_config #(.CLK_FREQ_HZ(4_000_000), .SCCB_FREQ_HZ(1_000_000), .NUM_ENTRIES(N),
    .DELAY_CYCLES(20), .USE_CUSTOM_TABLE(1'b1), .CUSTOM_TABLE(ROM_A)) u_a (
    .clk_i(clk), .reset_i(rst), .start_i(start[0]), .sioc_o(sioc[0]), .siod_o(siod[0]),
    .siod_oe_o(oe[0]), .busy_o(busy[0]), .done_o(done[0]), .index_o(idx[0]));

  ov7670_sccb_config #(.CLK_FREQ_HZ(4_000_000), .SCCB_FREQ_HZ(1_000_000), .NUM_ENTRIES(N),
    .DELAY_CYCLES(20), .USE_CUSTOM_TABLE(1'b1), .CUSTOM_TABLE(ROM_B)) u_b (
    .clk_i(clk), .reset_i(rst), .start_i(start[1]), .sioc_o(sioc[1]), .siod_o(siod[1]),
    .siod_oe_o(oe[1]), .busy_o(busy[1]), .done_o(done[1]), .index_o(idx[1]));

  ov7670_sccb_config #(.CLK_FREQ_HZ(4_000_000), .SCCB_FREQ_HZ(1_000_000), .NUM_ENTRIES(N),
    .DELAY_CYCLES(20), .USE_CUSTOM_TABLE(1'b1), .CUSTOM_TABLE(ROM_C)) u_c (
    .clk_i(clk), .reset_i(rst), .start_i(start[2]), .sioc_o(sioc[2]), .siod_o(siod[2]),
    .siod_oe_o(oe[2]), .busy_o(busy[2]), .done_o(done[2]), .index_o(idx[2]));

  // ---------------- bus decoder on the selected instance ----------------
  logic        prev_c = 1'b1, prev_l = 1'b1, cur_c, cur_l;
  bit          in_frame = 1'b0;
  int          nb = 0, cyc = 0, last_rise = 0, last_stop = -1;
  int          proto_err = 0, n_got = 0, n_gap = 0;
  logic [26:0] sh = '0;
  logic [23:0] got_mem [64];
  int          gap_mem [64];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_c = 1'b1; prev_l = 1'b1; in_frame = 1'b0; nb = 0;
    end else begin
      cur_c = sioc[sel];
      cur_l = oe[sel] ? siod[sel] : 1'b1;
      if (prev_c && cur_c && prev_l && !cur_l) begin
        if (in_frame) proto_err++;
        if (last_stop >= 0 && n_gap < 64) begin gap_mem[n_gap] = cyc - last_stop; n_gap++; end
        in_frame = 1'b1; nb = 0;
      end else if (prev_c && cur_c && !prev_l && cur_l) begin
        if (!in_frame || nb != 28) proto_err++;
        else if (n_got < 64) begin got_mem[n_got] = {sh[26:19], sh[17:10], sh[8:1]}; n_got++; end
        in_frame = 1'b0; last_stop = cyc;
      end
      if (!prev_c && cur_c) begin
        if (!in_frame || nb > 27) proto_err++;
        else if (nb == 27) nb = 28;
        else begin
          if (nb > 0 && cyc - last_rise != 4) proto_err++;
          if ((nb == 8 || nb == 17 || nb == 26) && oe[sel]) proto_err++;
          last_rise = cyc;
          sh = {sh[25:0], cur_l};
          nb++;
        end
      end
      prev_c = cur_c; prev_l = cur_l;
    end
  end

  // ---------------- checking ----------------
  int errors = 0, checks = 0, got_rd = 0, n_wr = 0;
  logic [23:0] exp_q [$];

  typedef struct {
    int dut; int mid; int exp_clks; int exp_idx; int exp_writes; int min_gap; int done_before;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rom_of(input int d);
    if (d == 0) return ROM_A;
    if (d == 1) return ROM_B;
    return ROM_C;
  endfunction

  task automatic push_expected(input logic [63:0] rom);
    logic [15:0] e;
    for (int i = 0; i < N; i++) begin
      e = rom[16*i +: 16];
      if (e == 16'hFFFF) break;
      if (e != 16'hFFF0) exp_q.push_back({8'h42, e});
    end
  endtask

  task automatic drain();
    while (got_rd < n_got) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(got_mem[got_rd]), 32'h0);
      else check("write_bytes", 32'(got_mem[got_rd]), 32'(exp_q.pop_front()));
      got_rd++;
      n_wr++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int c, p0, g0, mg;
    sel = v.dut;
    @(posedge clk); #1;
    check("done_before", 32'(done[v.dut]), 32'(v.done_before));
    p0 = proto_err; g0 = n_gap; n_wr = 0;
    push_expected(rom_of(v.dut));
    start[v.dut] = 1'b1;
    @(posedge clk); #1;
    start[v.dut] = 1'b0;
    check("accept_busy", 32'(busy[v.dut]), 32'h1);
    check("accept_done_clr", 32'(done[v.dut]), 32'h0);
    c = 0;
    while (!done[v.dut] && c < 2000) begin
      @(posedge clk); #1;
      c++;
      start[v.dut] = (v.mid != 0 && c == v.mid);
      drain();
    end
    start[v.dut] = 1'b0;
    drain();
    check("done_time", 32'(c), 32'(v.exp_clks));
    check("busy_at_done", 32'(busy[v.dut]), 32'h0);
    check("sioc_idle", 32'(sioc[v.dut]), 32'h1);
    check("final_index", 32'(idx[v.dut]), 32'(v.exp_idx));
    check("write_count", 32'(n_wr), 32'(v.exp_writes));
    check("missing_writes", 32'(exp_q.size()), 32'h0);
    check("protocol_errs", 32'(proto_err - p0), 32'h0);
    if (v.min_gap > 0) begin
      mg = 1000;
      for (int k = g0 + 1; k < n_gap; k++) if (gap_mem[k] < mg) mg = gap_mem[k];
      check("delay_gap_ok", 32'(mg >= v.min_gap), 32'h1);
    end
    exp_q.delete();
  endtask

  initial begin
    bit bad;
    vecs[0] = '{0, 0,  119, 1, 1, 0,  0};
    vecs[1] = '{0, 50, 119, 1, 1, 0,  1};
    vecs[2] = '{1, 0,  258, 3, 2, 20, 0};
    vecs[3] = '{1, 130, 258, 3, 2, 20, 1};
    vecs[4] = '{2, 0,  473, 0, 4, 0,  0};

    rst = 1'b1; start = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sioc", 32'(sioc), 32'h7);
    check("rst_oe", 32'(oe), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_index", 32'(idx[0]), 32'h0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (sioc !== 3'b111 || oe !== 3'b000 || busy !== 3'b000 || done !== 3'b000) bad = 1'b1;
    end
    check("idle_hold", 32'(bad), 32'h0);
    got_rd = n_got;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the middle of a bit phase, then a clean rewrite.
    sel = 2;
    start[2] = 1'b1;
    @(posedge clk); #1;
    start[2] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("busy_mid", 32'(busy[2]), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_sioc", 32'(sioc[2]), 32'h1);
    check("abort_oe", 32'(oe[2]), 32'h0);
    check("abort_busy", 32'(busy[2]), 32'h0);
    check("abort_done", 32'(done[2]), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_rd = n_got;
    exp_q.delete();
    run_vec('{2, 0, 473, 0, 4, 0, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
